dp_seq_scheduler: RTL and testbench

- Hardware sequencer that drives the DP systolic array through one complete pairwise alignment.
- Fetches query S and target T bases from two synchronous base buffers.
- Splits S into ceil(s_len/N) chunks of N bases and, per chunk, serially loads S, pulses s_update, then streams T and waits for DP busy to drop.
- Replaces the bench-side driving of new_seq, S, s_update, ack, T and valid.

---
 rtl/dp_seq_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dp_seq_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dp_seq_scheduler.sv
// dp_seq_scheduler: sequences S chunk loads, T streaming and drain waits through the DP systolic array for one alignment.
module dp_seq_scheduler #(
    parameter int N             = 8,
    parameter int BP_WIDTH      = 2,
    parameter int LEN_WIDTH     = 12,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] s_len,
    input  logic [LEN_WIDTH-1:0] t_len,
    output logic [LEN_WIDTH-1:0] s_rd_addr,
    input  logic [BP_WIDTH-1:0]  s_rd_data,
    output logic [LEN_WIDTH-1:0] t_rd_addr,
    input  logic [BP_WIDTH-1:0]  t_rd_data,
    output logic                 new_seq,
    output logic [BP_WIDTH-1:0]  S,
    output logic                 s_update,
    output logic                 ack,
    output logic [BP_WIDTH-1:0]  T,
    output logic                 valid,
    input  logic                 busy,
    output logic                 sched_busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_WIDTH-1:0] chunk_idx
);
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [LEN_WIDTH:0]   N_W    = (LEN_WIDTH + 1)'(N);
    localparam logic [LEN_WIDTH:0]   N_M1   = (LEN_WIDTH + 1)'(N - 1);
    localparam logic [LEN_WIDTH-1:0] LAST_K = LEN_WIDTH'(N - 1);
    localparam logic [DW-1:0]        LAST_D = DW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [3:0] {IDLE, NEWSEQ, FETCH_S, LOAD_S, UPDATE, FETCH_T, STREAM_T, DRAIN, DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] s_len_q, t_len_q, t_idx, cnt;
    logic [LEN_WIDTH:0]   n_chunks, s_idx;
    logic [DW-1:0]        dcnt;
    logic                 s_live;
    logic [BP_WIDTH-1:0]  s_q, t_q;

    // Buffer data arrives registered one cycle after its address, so it is
    // steered straight out; s_q/t_q hold zero-padding and last-value states.
    assign s_rd_addr = s_idx[LEN_WIDTH-1:0];
    assign t_rd_addr = t_idx;
    assign S         = s_live ? s_rd_data : s_q;
    assign T         = valid ? t_rd_data : t_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            new_seq    <= 1'b0;
            s_update   <= 1'b0;
            ack        <= 1'b0;
            valid      <= 1'b0;
            sched_busy <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            chunk_idx  <= '0;
            s_len_q    <= '0;
            t_len_q    <= '0;
            n_chunks   <= '0;
            s_idx      <= '0;
            t_idx      <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            s_live     <= 1'b0;
            s_q        <= '0;
            t_q        <= '0;
        end else begin
            new_seq  <= 1'b0;
            s_update <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (s_len == '0 || t_len == '0) begin
                        err <= 1'b1;
                    end else begin
                        s_len_q    <= s_len;
                        t_len_q    <= t_len;
                        n_chunks   <= ({1'b0, s_len} + N_M1) / N_W;
                        chunk_idx  <= '0;
                        new_seq    <= 1'b1;
                        sched_busy <= 1'b1;
                        state      <= NEWSEQ;
                    end
                end
                NEWSEQ: begin
                    ack   <= 1'b1;
                    s_idx <= N_M1;
                    state <= FETCH_S;
                end
                FETCH_S: begin
                    cnt    <= '0;
                    s_live <= s_idx < {1'b0, s_len_q};
                    s_idx  <= s_idx - 1'b1;
                    s_q    <= '0;
                    state  <= LOAD_S;
                end
                LOAD_S: if (cnt == LAST_K) begin
                    s_update <= 1'b1;
                    ack      <= 1'b0;
                    s_live   <= 1'b0;
                    s_q      <= S;
                    state    <= UPDATE;
                end else begin
                    cnt    <= cnt + 1'b1;
                    s_live <= s_idx < {1'b0, s_len_q};
                    s_idx  <= s_idx - 1'b1;
                    s_q    <= '0;
                end
                UPDATE: begin
                    ack   <= 1'b1;
                    t_idx <= '0;
                    state <= FETCH_T;
                end
                FETCH_T: begin
                    valid <= 1'b1;
                    cnt   <= '0;
                    t_idx <= t_idx + 1'b1;
                    state <= STREAM_T;
                end
                STREAM_T: if (cnt == t_len_q - 1'b1) begin
                    valid <= 1'b0;
                    t_q   <= T;
                    dcnt  <= '0;
                    state <= DRAIN;
                end else begin
                    cnt   <= cnt + 1'b1;
                    t_idx <= t_idx + 1'b1;
                end
                DRAIN: if (!busy) begin
                    if ({1'b0, chunk_idx} + 1'b1 < n_chunks) begin
                        chunk_idx <= chunk_idx + 1'b1;
                        s_idx     <= ({1'b0, chunk_idx} + 1'b1) * N_W + N_M1;
                        state     <= FETCH_S;
                    end else begin
                        done  <= 1'b1;
                        ack   <= 1'b0;
                        state <= DONE;
                    end
                end else if (dcnt == LAST_D) begin
                    err        <= 1'b1;
                    ack        <= 1'b0;
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                DONE: begin
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_seq_scheduler.sv
// tb_dp_seq_scheduler: directed runs of dp_seq_scheduler against synchronous base buffers with cycle-traced checks.
module tb_dp_seq_scheduler;
    localparam int N  = 8;
    localparam int TO = 24;

    logic        clk = 1'b0, reset_i = 1'b1, start = 1'b0, busy = 1'b0;
    logic [11:0] s_len = '0, t_len = '0, s_rd_addr, t_rd_addr, chunk_idx;
    logic [1:0]  s_rd_data = '0, t_rd_data = '0, S, T;
    logic        new_seq, s_update, ack, valid, sched_busy, done, err;

    logic [1:0] smem [0:4095];
    logic [1:0] tmem [0:4095];

    int vectors = 0, miscompares = 0;
    int tr_new[128], tr_s[128], tr_upd[128], tr_ack[128], tr_t[128], tr_valid[128];
    int tr_done[128], tr_err[128], tr_chunk[128], tr_sb[128];
    int n_new, n_upd, n_done, n_err, n_valid, n_sb;

    dp_seq_scheduler #(.N(N), .BP_WIDTH(2), .LEN_WIDTH(12), .DRAIN_TIMEOUT(TO)) dut (
        .clk(clk), .reset_i(reset_i), .start(start), .s_len(s_len), .t_len(t_len),
        .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data), .t_rd_addr(t_rd_addr), .t_rd_data(t_rd_data),
        .new_seq(new_seq), .S(S), .s_update(s_update), .ack(ack), .T(T), .valid(valid),
        .busy(busy), .sched_busy(sched_busy), .done(done), .err(err), .chunk_idx(chunk_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s_rd_data <= smem[s_rd_addr];
        t_rd_data <= tmem[t_rd_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " new_seq"}, int'(new_seq), 0);
        check({tag, " S"}, int'(S), 0);
        check({tag, " s_update"}, int'(s_update), 0);
        check({tag, " ack"}, int'(ack), 0);
        check({tag, " T"}, int'(T), 0);
        check({tag, " valid"}, int'(valid), 0);
        check({tag, " sched_busy"}, int'(sched_busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " err"}, int'(err), 0);
        check({tag, " chunk_idx"}, int'(chunk_idx), 0);
        check({tag, " s_rd_addr"}, int'(s_rd_addr), 0);
        check({tag, " t_rd_addr"}, int'(t_rd_addr), 0);
    endtask

    // Cycle 0 carries start; cycle c is sampled at the negedge inside it.
    // busy is high during cycles bf..bt; st2 re-pulses start mid-run.
    task automatic run(input int sl, input int tl, input int ncyc, input int bf, input int bt, input int st2);
        for (int i = 0; i < 128; i++) begin
            tr_new[i] = 0; tr_s[i] = 0; tr_upd[i] = 0; tr_ack[i] = 0; tr_t[i] = 0;
            tr_valid[i] = 0; tr_done[i] = 0; tr_err[i] = 0; tr_chunk[i] = 0; tr_sb[i] = 0;
        end
        {n_new, n_upd, n_done, n_err, n_valid, n_sb} = '0;
        @(negedge clk);
        s_len = 12'(sl);
        t_len = 12'(tl);
        start = 1'b1;
        busy  = (bf <= 0 && 0 <= bt);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            tr_new[c] = int'(new_seq); tr_s[c] = int'(S); tr_upd[c] = int'(s_update);
            tr_ack[c] = int'(ack); tr_t[c] = int'(T); tr_valid[c] = int'(valid);
            tr_done[c] = int'(done); tr_err[c] = int'(err); tr_chunk[c] = int'(chunk_idx);
            tr_sb[c] = int'(sched_busy);
            n_new += tr_new[c]; n_upd += tr_upd[c]; n_done += tr_done[c];
            n_err += tr_err[c]; n_valid += tr_valid[c]; n_sb += tr_sb[c];
            start = (c == st2);
            busy  = (c >= bf && c <= bt);
        end
    endtask

    // extra = cycles chunk 0's drain was stretched by busy
    task automatic check_run(input int sl, input int tl, input int extra);
        int l, nc, d, b, idx, e;
        l  = N + tl + 4;
        nc = (sl + N - 1) / N;
        d  = 2 + nc * l + extra;
        check("new_seq@1", tr_new[1], 1);
        check("ack@1", tr_ack[1], 0);
        check("sched_busy@1", tr_sb[1], 1);
        for (int c = 0; c < nc; c++) begin
            b = 2 + c * l + (c > 0 ? extra : 0);
            check($sformatf("chunk_idx@%0d", b), tr_chunk[b], c);
            check($sformatf("ack fetch_s@%0d", b), tr_ack[b], 1);
            e = 0;
            for (int k = 0; k < N; k++) begin
                idx = c * N + N - 1 - k;
                e = idx < sl ? int'(smem[idx]) : 0;
                check($sformatf("S ch%0d k%0d", c, k), tr_s[b + 1 + k], e);
            end
            check($sformatf("s_update@%0d", b + 1 + N), tr_upd[b + 1 + N], 1);
            check($sformatf("ack update@%0d", b + 1 + N), tr_ack[b + 1 + N], 0);
            check($sformatf("S hold@%0d", b + 1 + N), tr_s[b + 1 + N], e);
            check($sformatf("valid fetch_t@%0d", b + N + 2), tr_valid[b + N + 2], 0);
            for (int m = 0; m < tl; m++) begin
                check($sformatf("valid ch%0d m%0d", c, m), tr_valid[b + N + 3 + m], 1);
                check($sformatf("T ch%0d m%0d", c, m), tr_t[b + N + 3 + m], int'(tmem[m]));
            end
            check($sformatf("valid drain@%0d", b + N + 3 + tl), tr_valid[b + N + 3 + tl], 0);
            check($sformatf("ack drain@%0d", b + N + 3 + tl), tr_ack[b + N + 3 + tl], 1);
        end
        check($sformatf("done@%0d", d), tr_done[d], 1);
        check($sformatf("ack done@%0d", d), tr_ack[d], 0);
        check($sformatf("sched_busy idle@%0d", d + 1), tr_sb[d + 1], 0);
        check("new_seq count", n_new, 1);
        check("done count", n_done, 1);
        check("s_update count", n_upd, nc);
        check("valid count", n_valid, nc * tl);
        check("err count", n_err, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            smem[i] = 2'(((i * 5) ^ (i >> 2)) & 3);
            tmem[i] = 2'(((i * 3 + 1) ^ (i >> 1)) & 3);
        end
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_i = 1'b0;

        run(8, 5, 21, 1000, 0, 0);
        check_run(8, 5, 0);
        check("s_update@11", tr_upd[11], 1);
        check("done@19", tr_done[19], 1);

        run(20, 4, 52, 1000, 0, 0);
        check_run(20, 4, 0);

        run(0, 5, 6, 1000, 0, 0);
        check("s_len0 err@1", tr_err[1], 1);
        check("s_len0 err count", n_err, 1);
        check("s_len0 dp activity", n_new + n_upd + n_valid, 0);
        check("s_len0 sched_busy", n_sb, 0);

        run(5, 0, 6, 1000, 0, 0);
        check("t_len0 err@1", tr_err[1], 1);
        check("t_len0 err count", n_err, 1);
        check("t_len0 dp activity", n_new + n_upd + n_valid, 0);
        check("t_len0 sched_busy", n_sb, 0);

        run(16, 5, 58, 18, 37, 0);
        check_run(16, 5, 20);
        for (int c = 18; c <= 38; c++) begin
            check($sformatf("hold ack@%0d", c), tr_ack[c], 1);
            check($sformatf("hold chunk@%0d", c), tr_chunk[c], 0);
        end

        run(8, 5, 46, 18, 1000, 0);
        check("timeout err@41", tr_err[41], 0);
        check("timeout err@42", tr_err[42], 1);
        check("timeout err count", n_err, 1);
        check("timeout done count", n_done, 0);
        check("timeout sched_busy@41", tr_sb[41], 1);
        check("timeout sched_busy@42", tr_sb[42], 0);
        run(8, 5, 21, 1000, 0, 0);
        check_run(8, 5, 0);

        run(8, 5, 15, 1000, 0, 5);
        check("midrun new_seq count", n_new, 1);
        check("midrun s_update@11", tr_upd[11], 1);
        check("midrun valid@15", tr_valid[15], 1);
        check("midrun T@15", tr_t[15], int'(tmem[2]));
        reset_i = 1'b1;
        #1;
        chk_zero("midrun reset");
        @(negedge clk);
        reset_i = 1'b0;
        run(8, 5, 21, 1000, 0, 0);
        check_run(8, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
